// File: rtl/store_align_unit.sv
// Store alignment unit: turns one (addr, data, size) store into word-aligned
// memory write beats with byte enables and lane-shifted data. A store that
// crosses a 32-bit word boundary becomes two beats (low word, then addr+4),
// or is rejected when misaligned splitting is disabled.
module store_align_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  hi_we;
    logic [31:0] hi_wdata;

    logic [3:0]  mask;
    logic [31:0] lane_data;
    logic [7:0]  m8;
    logic [63:0] wide;
    logic        split;
    logic        reject;

    // Decode size into a byte mask and right-justified lane data, then shift both into place
    always_comb begin
        mask      = '0;
        lane_data = '0;
        case (st_size)
            2'd0: begin
                mask      = 4'b1111;
                lane_data = st_data;
            end
            2'd1: begin
                mask      = 4'b0011;
                lane_data = {16'h0000, st_data[15:0]};
            end
            2'd2: begin
                mask      = 4'b0001;
                lane_data = {24'h000000, st_data[7:0]};
            end
            default: begin
                mask      = '0;
                lane_data = '0;
            end
        endcase
        m8     = {4'b0000, mask} << st_addr[1:0];
        wide   = {32'h0000_0000, lane_data} << {st_addr[1:0], 3'b000};
        split  = |m8[7:4];
        reject = (st_size == 2'd3) || (split && !ALLOW_MISALIGNED);
    end

    assign st_ready = (state == IDLE);

    // Beat sequencer; the beat outputs are loaded on each transition so they stay stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            st_done       <= 1'b0;
            st_err        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= '0;
            hi_we         <= '0;
            hi_wdata      <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_valid) begin
                        if (reject) begin
                            st_err <= 1'b1;
                        end else begin
                            state         <= BEAT0;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {st_addr[31:2], 2'b00};
                            mem_we        <= m8[3:0];
                            mem_wdata     <= wide[31:0];
                            hi_we         <= m8[7:4];
                            hi_wdata      <= wide[63:32];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        // A non-empty upper enable set is exactly the word-crossing case
                        if (|hi_we) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_we    <= hi_we;
                            mem_wdata <= hi_wdata;
                        end else begin
                            state         <= IDLE;
                            st_done       <= 1'b1;
                            mem_req_valid <= 1'b0;
                            mem_addr      <= '0;
                            mem_wdata     <= '0;
                            mem_we        <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state         <= IDLE;
                        st_done       <= 1'b1;
                        mem_req_valid <= 1'b0;
                        mem_addr      <= '0;
                        mem_wdata     <= '0;
                        mem_we        <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: default instance plus one with
// misaligned splitting disabled.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_valid_nm;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_size;
    logic        mem_ready;

    logic        st_ready, st_done, st_err, mem_req_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    logic        st_ready_nm, st_done_nm, st_err_nm, mem_req_valid_nm;
    logic [31:0] mem_addr_nm, mem_wdata_nm;
    logic [3:0]  mem_we_nm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_align_unit dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done), .st_err(st_err),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we)
    );

    store_align_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid_nm), .st_ready(st_ready_nm),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done_nm), .st_err(st_err_nm),
        .mem_req_valid(mem_req_valid_nm), .mem_ready(mem_ready),
        .mem_addr(mem_addr_nm), .mem_wdata(mem_wdata_nm), .mem_we(mem_we_nm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] we,
                              input logic [31:0] wd);
        check({tag, "_valid"}, {31'd0, mem_req_valid}, 32'd1);
        check({tag, "_addr"},  mem_addr, a);
        check({tag, "_we"},    {28'd0, mem_we}, {28'd0, we});
        check({tag, "_wdata"}, mem_wdata, wd);
    endtask

    initial begin
        rst_n       = 1'b0;
        st_valid    = 1'b0;
        st_valid_nm = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        st_size     = '0;
        mem_ready   = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_we",    {28'd0, mem_we}, 32'd0);
        check("rst_done",  {31'd0, st_done}, 32'd0);
        check("rst_err",   {31'd0, st_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {31'd0, st_ready}, 32'd1);

        // 1: aligned word
        issue(32'h0000_0100, 32'hDEAD_BEEF, 2'd0);
        check_beat("t1_b0", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        check("t1_ready_busy", {31'd0, st_ready}, 32'd0);
        check("t1_done_early", {31'd0, st_done}, 32'd0);
        tick();
        check("t1_done", {31'd0, st_done}, 32'd1);
        check("t1_idle_valid", {31'd0, mem_req_valid}, 32'd0);
        check("t1_ready", {31'd0, st_ready}, 32'd1);
        tick();
        check("t1_done_pulse", {31'd0, st_done}, 32'd0);

        // 2: byte in top lane
        issue(32'h0000_0203, 32'h0000_00A5, 2'd2);
        check_beat("t2_b0", 32'h0000_0200, 4'b1000, 32'hA500_0000);
        tick();
        check("t2_done", {31'd0, st_done}, 32'd1);

        // 3a: halfword in upper half, upper data bits ignored
        issue(32'h0000_0302, 32'hFFFF_1234, 2'd1);
        check_beat("t3a_b0", 32'h0000_0300, 4'b1100, 32'h1234_0000);
        tick();
        check("t3a_done", {31'd0, st_done}, 32'd1);

        // 3b: halfword crossing the word boundary
        issue(32'h0000_0303, 32'hFFFF_1234, 2'd1);
        check_beat("t3b_b0", 32'h0000_0300, 4'b1000, 32'h3400_0000);
        tick();
        check_beat("t3b_b1", 32'h0000_0304, 4'b0001, 32'h0000_0012);
        check("t3b_done_early", {31'd0, st_done}, 32'd0);
        tick();
        check("t3b_done", {31'd0, st_done}, 32'd1);

        // 4: misaligned word with backpressure on both beats
        mem_ready = 1'b0;
        issue(32'h0000_0401, 32'h1122_3344, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check_beat("t4_b0_hold", 32'h0000_0400, 4'b1110, 32'h2233_4400);
            check("t4_b0_done", {31'd0, st_done}, 32'd0);
            tick();
        end
        check_beat("t4_b0_last", 32'h0000_0400, 4'b1110, 32'h2233_4400);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("t4_b1_hold", 32'h0000_0404, 4'b0001, 32'h0000_0011);
            check("t4_b1_done", {31'd0, st_done}, 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("t4_done", {31'd0, st_done}, 32'd1);
        tick();
        check("t4_single_done", {31'd0, st_done}, 32'd0);

        // 5a: reserved size rejected
        issue(32'h0000_0500, 32'h1234_5678, 2'd3);
        check("t5a_err", {31'd0, st_err}, 32'd1);
        check("t5a_valid", {31'd0, mem_req_valid}, 32'd0);
        check("t5a_ready", {31'd0, st_ready}, 32'd1);
        tick();
        check("t5a_err_pulse", {31'd0, st_err}, 32'd0);
        check("t5a_valid2", {31'd0, mem_req_valid}, 32'd0);

        // 5b: crossing word rejected when splitting disabled
        st_addr     = 32'h0000_0FFD;
        st_data     = 32'hCAFE_F00D;
        st_size     = 2'd0;
        st_valid_nm = 1'b1;
        tick();
        st_valid_nm = 1'b0;
        check("t5b_err", {31'd0, st_err_nm}, 32'd1);
        check("t5b_valid", {31'd0, mem_req_valid_nm}, 32'd0);
        check("t5b_other_quiet", {31'd0, mem_req_valid}, 32'd0);
        tick();
        check("t5b_err_pulse", {31'd0, st_err_nm}, 32'd0);
        check("t5b_valid2", {31'd0, mem_req_valid_nm}, 32'd0);

        // 5c: non-crossing halfword still accepted with splitting disabled
        st_addr     = 32'h0000_0FFE;
        st_data     = 32'h0000_BEEF;
        st_size     = 2'd1;
        st_valid_nm = 1'b1;
        tick();
        st_valid_nm = 1'b0;
        check("t5c_valid", {31'd0, mem_req_valid_nm}, 32'd1);
        check("t5c_we", {28'd0, mem_we_nm}, 32'h0000_000C);
        check("t5c_wdata", mem_wdata_nm, 32'hBEEF_0000);
        check("t5c_err", {31'd0, st_err_nm}, 32'd0);
        tick();
        check("t5c_done", {31'd0, st_done_nm}, 32'd1);

        // 6a: crossing store at top of address space wraps beat1 to 0
        issue(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'd0);
        check_beat("t6_b0", 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000);
        tick();
        check_beat("t6_b1", 32'h0000_0000, 4'b0011, 32'h0000_AABB);
        tick();
        check("t6_done", {31'd0, st_done}, 32'd1);

        // 6b: reset during BEAT0 of a crossing store
        mem_ready = 1'b0;
        issue(32'h0000_0602, 32'h5566_7788, 2'd0);
        check_beat("t6b_b0", 32'h0000_0600, 4'b1100, 32'h7788_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6b_rst_valid", {31'd0, mem_req_valid}, 32'd0);
        check("t6b_rst_addr",  mem_addr, 32'd0);
        check("t6b_rst_wdata", mem_wdata, 32'd0);
        check("t6b_rst_we",    {28'd0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6b_no_beat", {31'd0, mem_req_valid}, 32'd0);
            check("t6b_no_done", {31'd0, st_done}, 32'd0);
        end
        check("t6b_ready", {31'd0, st_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
